rv_decode_stage: RTL and testbench

Parametrised second-generation decode stage for the atomRVCORE pipeline, placed between fetch and execute.
- Decodes RV32I instructions into control flags, a sign-extended immediate and an ALU opcode.
- Contains the integer register file with write-first bypass and applies EX/WB operand forwarding.
- Adds what the previous decoder lacked: a valid/ready handshake on both sides, load-use hazard stalling with bubble insertion, flush, and illegal-opcode flagging.

---
 rtl/rv_decode_stage_if.sv | 13 +
 rtl/rv_decode_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Fetch-to-decode handshake bundle for rv_decode_stage.
// Fetch drives the instruction and PC, and decode answers with in_ready_o.
interface rv_decode_stage_if #(
  parameter int DATAWIDTH = 32
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [31:0]          instr_i;
  logic [DATAWIDTH-1:0] pc_i;

  modport master (output in_valid_i, output instr_i, output pc_i, input in_ready_o);
  modport slave  (input in_valid_i, input instr_i, input pc_i, output in_ready_o);
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decode, register file with write-first bypass, operand forwarding,
// valid/ready output register with load-use stall, flush and illegal-opcode flagging.
module rv_decode_stage #(
  parameter int DATAWIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REGISTERS      = 32,
  parameter int ALUOP_WIDTH    = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  rv_decode_stage_if.slave          fetch,
  input  logic                      flush_i,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATAWIDTH-1:0]      wb_data_i,
  input  logic [DATAWIDTH-1:0]      ex_result_i,
  input  logic [1:0]                fwd1_i,
  input  logic [1:0]                fwd2_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATAWIDTH-1:0]      pc_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [DATAWIDTH-1:0]      operand_a_o,
  output logic [DATAWIDTH-1:0]      rs2_data_o,
  output logic [DATAWIDTH-1:0]      operand_b_o,
  output logic [DATAWIDTH-1:0]      immed_o,
  output logic [ALUOP_WIDTH-1:0]    aluop_o,
  output logic                      rwr_en_o,
  output logic                      dr_en_o,
  output logic                      dwr_en_o,
  output logic                      sb_en_o,
  output logic                      jal_o,
  output logic                      jalr_o,
  output logic                      lui_o,
  output logic                      auipc_o,
  output logic                      ill_o
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [DATAWIDTH-1:0]      pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATAWIDTH-1:0]      opa;
    logic [DATAWIDTH-1:0]      rs2_data;
    logic [DATAWIDTH-1:0]      opb;
    logic [DATAWIDTH-1:0]      immed;
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic                      rwr_en;
    logic                      dr_en;
    logic                      dwr_en;
    logic                      sb_en;
    logic                      jal;
    logic                      jalr;
    logic                      lui;
    logic                      auipc;
    logic                      ill;
  } bundle_t;

  // Arithmetic/logic opcode shared by R and I types; only R treats funct7 as a sub select.
  function automatic logic [5:0] arith_op(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [5:0] op;
    case (f3)
      3'b000:  op = (alt && is_r) ? 6'd10 : 6'd1;
      3'b001:  op = 6'd2;
      3'b010:  op = 6'd3;
      3'b011:  op = 6'd4;
      3'b100:  op = 6'd5;
      3'b101:  op = alt ? 6'd7 : 6'd6;
      3'b110:  op = 6'd8;
      3'b111:  op = 6'd9;
      default: op = 6'd0;
    endcase
    return op;
  endfunction

  function automatic logic [5:0] branch_op(input logic [2:0] f3);
    logic [5:0] op;
    case (f3)
      3'b000:  op = 6'd11;
      3'b001:  op = 6'd12;
      3'b100:  op = 6'd13;
      3'b101:  op = 6'd14;
      3'b110:  op = 6'd15;
      3'b111:  op = 6'd16;
      default: op = 6'd0;
    endcase
    return op;
  endfunction

  logic [DATAWIDTH-1:0]      regs_q [REGISTERS];
  bundle_t                   bundle_q, bundle_d, dec_s;
  logic                      out_valid_q, out_valid_d;
  logic [31:0]               instr_s, imm32_s;
  logic [5:0]                alu6_s;
  logic                      alt_s, use_rs1_s, use_rs2_s, opb_imm_s;
  logic                      rwr_s, dr_s, dwr_s, sb_s, jal_s, jalr_s, lui_s, auipc_s, ill_s;
  logic [REG_ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
  logic [DATAWIDTH-1:0]      rs1_rf_s, rs2_rf_s, opa_s, rs2_data_s;
  logic                      advance_s, hazard_s;

  assign instr_s = fetch.instr_i;
  assign alt_s   = (instr_s[31:25] == 7'b0100000);

  // Opcode classification, immediate formats and ALU opcode.
  always_comb begin
    rwr_s = 1'b0; dr_s = 1'b0; dwr_s = 1'b0; sb_s = 1'b0; jal_s = 1'b0;
    jalr_s = 1'b0; lui_s = 1'b0; auipc_s = 1'b0; ill_s = 1'b0;
    use_rs1_s = 1'b0; use_rs2_s = 1'b0; opb_imm_s = 1'b1;
    imm32_s = 32'h0; alu6_s = 6'd0;
    case (instr_s[6:0])
      OP_R: begin
        rwr_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; opb_imm_s = 1'b0;
        alu6_s = arith_op(instr_s[14:12], alt_s, 1'b1);
      end
      OP_I: begin
        rwr_s = 1'b1; use_rs1_s = 1'b1;
        imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
        alu6_s = arith_op(instr_s[14:12], alt_s, 1'b0);
      end
      OP_LOAD: begin
        rwr_s = 1'b1; dr_s = 1'b1; use_rs1_s = 1'b1; alu6_s = 6'd1;
        imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OP_STORE: begin
        dwr_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; opb_imm_s = 1'b0; alu6_s = 6'd1;
        imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
      end
      OP_BRANCH: begin
        sb_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; opb_imm_s = 1'b0;
        alu6_s = branch_op(instr_s[14:12]);
        imm32_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
      end
      OP_JAL: begin
        rwr_s = 1'b1; jal_s = 1'b1; alu6_s = 6'd17;
        imm32_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
      end
      OP_JALR: begin
        rwr_s = 1'b1; jalr_s = 1'b1; use_rs1_s = 1'b1; alu6_s = 6'd1;
        imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OP_LUI: begin
        rwr_s = 1'b1; lui_s = 1'b1; imm32_s = {instr_s[31:12], 12'h000};
      end
      OP_AUIPC: begin
        rwr_s = 1'b1; auipc_s = 1'b1; alu6_s = 6'd1; imm32_s = {instr_s[31:12], 12'h000};
      end
      default: ill_s = 1'b1;
    endcase
  end

  assign rs1_s = use_rs1_s ? REG_ADDR_WIDTH'(instr_s[19:15]) : {REG_ADDR_WIDTH{1'b0}};
  assign rs2_s = use_rs2_s ? REG_ADDR_WIDTH'(instr_s[24:20]) : {REG_ADDR_WIDTH{1'b0}};
  assign rd_s  = rwr_s     ? REG_ADDR_WIDTH'(instr_s[11:7])  : {REG_ADDR_WIDTH{1'b0}};

  // Register file reads with x0 hardwired and same-cycle write-back bypass, then forwarding.
  always_comb begin
    if (rs1_s == {REG_ADDR_WIDTH{1'b0}}) rs1_rf_s = {DATAWIDTH{1'b0}};
    else if (wb_en_i && (wb_rd_i == rs1_s)) rs1_rf_s = wb_data_i;
    else rs1_rf_s = regs_q[rs1_s];
    if (rs2_s == {REG_ADDR_WIDTH{1'b0}}) rs2_rf_s = {DATAWIDTH{1'b0}};
    else if (wb_en_i && (wb_rd_i == rs2_s)) rs2_rf_s = wb_data_i;
    else rs2_rf_s = regs_q[rs2_s];
    case (fwd1_i)
      2'd1:    opa_s = ex_result_i;
      2'd2:    opa_s = wb_data_i;
      default: opa_s = rs1_rf_s;
    endcase
    case (fwd2_i)
      2'd1:    rs2_data_s = ex_result_i;
      2'd2:    rs2_data_s = wb_data_i;
      default: rs2_data_s = rs2_rf_s;
    endcase
  end

  // Assemble the bundle that would be captured this cycle.
  always_comb begin
    dec_s          = '0;
    dec_s.pc       = fetch.pc_i;
    dec_s.rs1      = rs1_s;
    dec_s.rs2      = rs2_s;
    dec_s.rd       = rd_s;
    dec_s.opa      = opa_s;
    dec_s.rs2_data = rs2_data_s;
    dec_s.immed    = DATAWIDTH'($signed(imm32_s));
    dec_s.opb      = opb_imm_s ? DATAWIDTH'($signed(imm32_s)) : rs2_data_s;
    dec_s.aluop    = ALUOP_WIDTH'(alu6_s);
    dec_s.rwr_en   = rwr_s;
    dec_s.dr_en    = dr_s;
    dec_s.dwr_en   = dwr_s;
    dec_s.sb_en    = sb_s;
    dec_s.jal      = jal_s;
    dec_s.jalr     = jalr_s;
    dec_s.lui      = lui_s;
    dec_s.auipc    = auipc_s;
    dec_s.ill      = ill_s;
  end

  // A load in the output register stalls any consumer; unused fields decode to x0 and never match.
  assign hazard_s = out_valid_q && bundle_q.dr_en && (bundle_q.rd != {REG_ADDR_WIDTH{1'b0}}) &&
                    ((bundle_q.rd == rs1_s) || (bundle_q.rd == rs2_s));
  assign advance_s = out_ready_i || !out_valid_q;
  assign fetch.in_ready_o = advance_s && !hazard_s;

  // Output register next state: flush, capture, or bubble when advancing; hold otherwise.
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (advance_s) begin
      if (flush_i) begin
        out_valid_d = 1'b0;
      end else if (fetch.in_valid_i && !hazard_s) begin
        bundle_d    = dec_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Register file write port; writes land regardless of stall or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REGISTERS; i++) regs_q[i] <= {DATAWIDTH{1'b0}};
    end else if (wb_en_i && (wb_rd_i != {REG_ADDR_WIDTH{1'b0}})) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign pc_o        = bundle_q.pc;
  assign rs1_o       = bundle_q.rs1;
  assign rs2_o       = bundle_q.rs2;
  assign rd_o        = bundle_q.rd;
  assign operand_a_o = bundle_q.opa;
  assign rs2_data_o  = bundle_q.rs2_data;
  assign operand_b_o = bundle_q.opb;
  assign immed_o     = bundle_q.immed;
  assign aluop_o     = bundle_q.aluop;
  assign rwr_en_o    = bundle_q.rwr_en;
  assign dr_en_o     = bundle_q.dr_en;
  assign dwr_en_o    = bundle_q.dwr_en;
  assign sb_en_o     = bundle_q.sb_en;
  assign jal_o       = bundle_q.jal;
  assign jalr_o      = bundle_q.jalr;
  assign lui_o       = bundle_q.lui;
  assign auipc_o     = bundle_q.auipc;
  assign ill_o       = bundle_q.ill;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model of decode, register file and handshake.
module tb_rv_decode_stage;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  rv_decode_stage_if #(.DATAWIDTH(32)) fif ();

  logic        flush_i, wb_en_i, out_ready_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i, ex_result_i;
  logic [1:0]  fwd1_i, fwd2_i;
  logic        out_valid_o;
  logic [31:0] pc_o, operand_a_o, rs2_data_o, operand_b_o, immed_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [5:0]  aluop_o;
  logic        rwr_en_o, dr_en_o, dwr_en_o, sb_en_o, jal_o, jalr_o, lui_o, auipc_o, ill_o;

  rv_decode_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fetch(fif),
    .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .ex_result_i(ex_result_i), .fwd1_i(fwd1_i), .fwd2_i(fwd2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .operand_a_o(operand_a_o),
    .rs2_data_o(rs2_data_o), .operand_b_o(operand_b_o), .immed_o(immed_o), .aluop_o(aluop_o),
    .rwr_en_o(rwr_en_o), .dr_en_o(dr_en_o), .dwr_en_o(dwr_en_o), .sb_en_o(sb_en_o),
    .jal_o(jal_o), .jalr_o(jalr_o), .lui_o(lui_o), .auipc_o(auipc_o), .ill_o(ill_o)
  );

  // flags: {rwr, dr, dwr, sb, jal, jalr, lui, auipc, ill}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] opa, rs2d, opb, imm;
    logic [5:0]  aluop;
    logic [8:0]  flags;
  } exp_t;

  localparam logic [5:0] ALU_TAB [8] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
  localparam logic [5:0] BR_TAB  [8] = '{6'd11, 6'd12, 6'd0, 6'd0, 6'd13, 6'd14, 6'd15, 6'd16};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mreg [32];
  exp_t        mexp;
  bit          mvalid;
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf(input logic [4:0] i);
    if (i == 5'd0) return 32'h0;
    if (wb_en_i && wb_rd_i == i) return wb_data_i;
    return mreg[i];
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rfv);
    if (sel == 2'd1) return ex_result_i;
    if (sel == 2'd2) return wb_data_i;
    return rfv;
  endfunction

  // Reference decode straight from the ISA field layouts, using signed arithmetic for immediates.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e; int v; bit u1, u2, wr, useimm, alt; logic [2:0] f3;
    e = '0; v = 0; u1 = 0; u2 = 0; wr = 0; useimm = 1;
    f3 = ins[14:12];
    alt = (ins[31:25] == 7'b0100000);
    case (ins[6:0])
      7'h33: begin
        u1 = 1; u2 = 1; wr = 1; useimm = 0; e.aluop = ALU_TAB[f3];
        if (alt && f3 == 3'd0) e.aluop = 6'd10;
        if (alt && f3 == 3'd5) e.aluop = 6'd7;
      end
      7'h13: begin
        u1 = 1; wr = 1; v = $signed(ins[31:20]); e.aluop = ALU_TAB[f3];
        if (alt && f3 == 3'd5) e.aluop = 6'd7;
      end
      7'h03: begin u1 = 1; wr = 1; v = $signed(ins[31:20]); e.aluop = 6'd1; e.flags[7] = 1'b1; end
      7'h23: begin
        u1 = 1; u2 = 1; useimm = 0; v = $signed({ins[31:25], ins[11:7]});
        e.aluop = 6'd1; e.flags[6] = 1'b1;
      end
      7'h63: begin
        u1 = 1; u2 = 1; useimm = 0; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        e.aluop = BR_TAB[f3]; e.flags[5] = 1'b1;
      end
      7'h6F: begin
        wr = 1; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        e.aluop = 6'd17; e.flags[4] = 1'b1;
      end
      7'h67: begin u1 = 1; wr = 1; v = $signed(ins[31:20]); e.aluop = 6'd1; e.flags[3] = 1'b1; end
      7'h37: begin wr = 1; v = {ins[31:12], 12'h000}; e.aluop = 6'd0; e.flags[2] = 1'b1; end
      7'h17: begin wr = 1; v = {ins[31:12], 12'h000}; e.aluop = 6'd1; e.flags[1] = 1'b1; end
      default: e.flags[0] = 1'b1;
    endcase
    e.flags[8] = wr;
    e.pc   = pc;
    e.imm  = v;
    e.rs1  = u1 ? ins[19:15] : 5'd0;
    e.rs2  = u2 ? ins[24:20] : 5'd0;
    e.rd   = wr ? ins[11:7] : 5'd0;
    e.opa  = pick(fwd1_i, rf(e.rs1));
    e.rs2d = pick(fwd2_i, rf(e.rs2));
    e.opb  = useimm ? e.imm : e.rs2d;
    return e;
  endfunction

  // One clock of stimulus: check in_ready, clock, advance the model, check the output register.
  task automatic cycle();
    exp_t d; bit hz, adv;
    #1;
    d   = model_decode(fif.instr_i, fif.pc_i);
    adv = out_ready_i || !mvalid;
    hz  = mvalid && mexp.flags[7] && (mexp.rd != 5'd0) && (mexp.rd == d.rs1 || mexp.rd == d.rs2);
    last_ready = fif.in_ready_o;
    chk("in_ready", {31'd0, fif.in_ready_o}, {31'd0, adv && !hz});
    @(posedge clk_i);
    if (wb_en_i && wb_rd_i != 5'd0) mreg[wb_rd_i] = wb_data_i;
    if (adv) begin
      if (flush_i) mvalid = 0;
      else if (fif.in_valid_i && !hz) begin mexp = d; mvalid = 1; end
      else mvalid = 0;
    end
    #1;
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, mvalid});
    if (mvalid) begin
      chk("pc", pc_o, mexp.pc);
      chk("rs1", {27'd0, rs1_o}, {27'd0, mexp.rs1});
      chk("rs2", {27'd0, rs2_o}, {27'd0, mexp.rs2});
      chk("rd", {27'd0, rd_o}, {27'd0, mexp.rd});
      chk("operand_a", operand_a_o, mexp.opa);
      chk("rs2_data", rs2_data_o, mexp.rs2d);
      chk("operand_b", operand_b_o, mexp.opb);
      chk("immed", immed_o, mexp.imm);
      chk("aluop", {26'd0, aluop_o}, {26'd0, mexp.aluop});
      chk("flags", {23'd0, rwr_en_o, dr_en_o, dwr_en_o, sb_en_o, jal_o, jalr_o, lui_o, auipc_o, ill_o},
          {23'd0, mexp.flags});
    end
  endtask

  task automatic model_reset();
    mvalid = 0;
    mexp = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] rnd;
    fif.in_valid_i = 1'b0; fif.instr_i = 32'h0; fif.pc_i = 32'h0;
    flush_i = 1'b0; wb_en_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0; ex_result_i = 32'h0;
    fwd1_i = 2'd0; fwd2_i = 2'd0; out_ready_i = 1'b1;
    model_reset();

    #12;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_opa", operand_a_o, 32'd0);
    chk("rst_aluop_flags", {17'd0, aluop_o, rwr_en_o, dr_en_o, dwr_en_o, sb_en_o, jal_o, jalr_o,
        lui_o, auipc_o, ill_o}, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Register write then addi x6,x5,-1
    wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
    cycle();
    wb_en_i = 1'b0; fif.in_valid_i = 1'b1; fif.instr_i = 32'hFFF28313; fif.pc_i = 32'h100;
    cycle();
    chk("addi_opa", operand_a_o, 32'h1234);
    chk("addi_imm", immed_o, 32'hFFFFFFFF);
    chk("addi_aluop", {26'd0, aluop_o}, 32'd1);
    chk("addi_rwr", {31'd0, rwr_en_o}, 32'd1);
    // Same-cycle write and read of x9
    wb_en_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h1234; fif.instr_i = 32'hFFF48313; fif.pc_i = 32'h104;
    cycle();
    chk("bypass_opa", operand_a_o, 32'h1234);
    wb_en_i = 1'b0;

    // Load-use: lw x7,0(x1) ; add x8,x7,x2
    fif.instr_i = 32'h0000A383; fif.pc_i = 32'h108;
    cycle();
    fif.instr_i = 32'h00238433; fif.pc_i = 32'h10C;
    cycle();
    chk("lu_stall_ready", {31'd0, last_ready}, 32'd0);
    chk("lu_bubble", {31'd0, out_valid_o}, 32'd0);
    cycle();
    chk("lu_issue_valid", {31'd0, out_valid_o}, 32'd1);
    chk("lu_issue_rd", {27'd0, rd_o}, 32'd8);
    // lw then add x8,x0,x2: no stall
    fif.instr_i = 32'h0000A383; fif.pc_i = 32'h110;
    cycle();
    fif.instr_i = 32'h00200433; fif.pc_i = 32'h114;
    cycle();
    chk("nolu_ready", {31'd0, last_ready}, 32'd1);
    chk("nolu_pc", pc_o, 32'h114);

    // Back-pressure with beq x1,x2,+8 held
    fif.instr_i = 32'h00208463; fif.pc_i = 32'h200;
    cycle();
    out_ready_i = 1'b0; fif.instr_i = 32'hFFF28313; fif.pc_i = 32'h204;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", {31'd0, last_ready}, 32'd0);
      chk("bp_aluop", {26'd0, aluop_o}, 32'd11);
      chk("bp_pc", pc_o, 32'h200);
      chk("bp_imm", immed_o, 32'd8);
    end
    out_ready_i = 1'b1;
    cycle();
    chk("bp_next_pc", pc_o, 32'h204);

    // Forwarding on sub x3,x1,x2
    fif.instr_i = 32'h402081B3; fif.pc_i = 32'h208;
    fwd1_i = 2'd1; ex_result_i = 32'hAA; fwd2_i = 2'd2; wb_data_i = 32'h55;
    cycle();
    chk("fwd_opa", operand_a_o, 32'hAA);
    chk("fwd_opb", operand_b_o, 32'h55);
    chk("fwd_aluop", {26'd0, aluop_o}, 32'd10);
    fwd1_i = 2'd0; fwd2_i = 2'd0;

    // Flush, then an illegal word
    flush_i = 1'b1; fif.instr_i = 32'hFFF28313; fif.pc_i = 32'h20C;
    cycle();
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    flush_i = 1'b0; fif.instr_i = 32'h0000007F; fif.pc_i = 32'h210;
    cycle();
    chk("ill_flag", {31'd0, ill_o}, 32'd1);
    chk("ill_rwr", {31'd0, rwr_en_o}, 32'd0);

    // Randomized traffic with registers confined to a small set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      rnd[6:0]   = OPS[$urandom_range(0, 9)];
      rnd[11:7]  = 5'($urandom_range(0, 3));
      rnd[19:15] = 5'($urandom_range(0, 3));
      rnd[24:20] = 5'($urandom_range(0, 3));
      fif.instr_i    = rnd;
      fif.pc_i       = $urandom();
      fif.in_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i    = ($urandom_range(0, 3) != 0);
      flush_i        = ($urandom_range(0, 15) == 0);
      wb_en_i        = ($urandom_range(0, 1) != 0);
      wb_rd_i        = 5'($urandom_range(0, 7));
      wb_data_i      = $urandom();
      ex_result_i    = $urandom();
      fwd1_i         = 2'($urandom_range(0, 3));
      fwd2_i         = 2'($urandom_range(0, 3));
      cycle();
    end

    // Asynchronous reset in the middle of traffic
    fif.in_valid_i = 1'b1; out_ready_i = 1'b1; flush_i = 1'b0; wb_en_i = 1'b0;
    fwd1_i = 2'd0; fwd2_i = 2'd0; fif.instr_i = 32'hFFF28313; fif.pc_i = 32'h300;
    cycle();
    chk("pre_reset_valid", {31'd0, out_valid_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset_valid", {31'd0, out_valid_o}, 32'd0);
    model_reset();
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    for (int r = 1; r < 32; r++) begin
      fif.instr_i = {7'd0, 5'(r), 5'(r), 3'd0, 5'd1, 7'h33};
      cycle();
      chk("rf_cleared", operand_a_o, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
